// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// uart_frame_pkg : state encoding and framing constants for uart_frame_ctrl
// Revision: 1.0
// ============================================================================
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// uart_frame_buf : DEPTH x 8 payload register file, sync write / async read
// Revision: 1.0
// ============================================================================
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Addresses past a non-power-of-two depth read as zero instead of X.
    assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// uart_frame_ctrl : sync/cmd/len/payload/chk frame parser with held-frame
// handshake. Optional inter-byte timeout enabled by UART_FRAME_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 8680
) (
    input  logic                                               i_Clock,
    input  logic                                               i_Rst_L,
    input  logic                                               i_RX_DV,
    input  logic [7:0]                                         i_RX_Byte,
    output logic                                               o_Frame_Valid,
    output logic [7:0]                                         o_Cmd,
    output logic [7:0]                                         o_Len,
    input  logic [((MAX_LEN > 1) ? $clog2(MAX_LEN) : 1)-1:0]   i_Rd_Addr,
    output logic [7:0]                                         o_Rd_Data,
    input  logic                                               i_Frame_Ack,
    output logic                                               o_Err_Chk,
    output logic                                               o_Err_Len,
    output logic                                               o_Err_Ovf,
    output logic                                               o_Err_Tmo
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         IDX_W     = $clog2(MAX_LEN) + 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2) begin : g_param_check
        $error("uart_frame_ctrl: MAX_LEN must be 1..255 and TIMEOUT_CLKS >= 2");
    end

    state_t           state;
    logic [7:0]       cmd;
    logic [7:0]       len;
    logic [7:0]       acc;
    logic [IDX_W-1:0] idx;
    logic [8:0]       idx_next;
    logic             frame_valid;
    logic             err_chk;
    logic             err_len;
    logic             err_ovf;
    logic             buf_we;

    assign idx_next = 9'(idx) + 9'd1;
    assign buf_we   = (state == ST_PAYLOAD) && i_RX_DV;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_tmo;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= ST_IDLE;
            cmd         <= 8'h00;
            len         <= 8'h00;
            acc         <= 8'h00;
            idx         <= '0;
            frame_valid <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_ovf     <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            tmo_cnt     <= '0;
            err_tmo     <= 1'b0;
`endif
        end else begin
            err_chk <= 1'b0;
            err_len <= 1'b0;
            err_ovf <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_RX_DV && i_RX_Byte == SYNC_BYTE) state <= ST_CMD;
                end
                ST_CMD: begin
                    if (i_RX_DV) begin
                        cmd   <= i_RX_Byte;
                        acc   <= i_RX_Byte;
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_RX_DV) begin
                        len <= i_RX_Byte;
                        acc <= acc ^ i_RX_Byte;
                        if (i_RX_Byte > MAX_LEN_B) begin
                            err_len <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (i_RX_Byte == 8'h00) begin
                            state <= ST_CHK;
                        end else begin
                            idx   <= '0;
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (i_RX_DV) begin
                        acc <= acc ^ i_RX_Byte;
                        idx <= idx + 1'b1;
                        if (idx_next == {1'b0, len}) state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (i_RX_DV) begin
                        if (i_RX_Byte == acc) begin
                            frame_valid <= 1'b1;
                            state       <= ST_HOLD;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    // A strobe coinciding with the ack belongs to the next frame.
                    if (i_Frame_Ack) begin
                        frame_valid <= 1'b0;
                        state <= (i_RX_DV && i_RX_Byte == SYNC_BYTE) ? ST_CMD : ST_IDLE;
                    end else if (i_RX_DV) begin
                        err_ovf <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef UART_FRAME_TIMEOUT_EN
            err_tmo <= 1'b0;
            if (state inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK}) begin
                if (i_RX_DV) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt <= '0;
                    err_tmo <= 1'b1;
                    state   <= ST_IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (i_Clock),
        .wr_en   (buf_we),
        .wr_addr (idx[AW-1:0]),
        .wr_data (i_RX_Byte),
        .rd_addr (i_Rd_Addr),
        .rd_data (o_Rd_Data)
    );

    assign o_Frame_Valid = frame_valid;
    assign o_Cmd         = cmd;
    assign o_Len         = len;
    assign o_Err_Chk     = err_chk;
    assign o_Err_Len     = err_len;
    assign o_Err_Ovf     = err_ovf;
`ifdef UART_FRAME_TIMEOUT_EN
    assign o_Err_Tmo     = err_tmo;
`else
    assign o_Err_Tmo     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
// tb_uart_frame_ctrl : frame-level random stimulus with an event scoreboard
// Revision: 1.0
// ============================================================================
module tb_uart_frame_ctrl;
    import uart_frame_pkg::*;

    localparam int MAX_LEN      = 16;
    localparam int TIMEOUT_CLKS = 100;
    localparam int AW           = $clog2(MAX_LEN);

    localparam logic [2:0] K_VALID = 3'd0;
    localparam logic [2:0] K_CHK   = 3'd1;
    localparam logic [2:0] K_LEN   = 3'd2;
    localparam logic [2:0] K_OVF   = 3'd3;
    localparam logic [2:0] K_TMO   = 3'd4;

    typedef struct packed {
        logic [2:0]           kind;
        logic [31:0]          cyc;
        logic [7:0]           cmd;
        logic [7:0]           len;
        logic [MAX_LEN*8-1:0] pay;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          frame_valid;
    logic [7:0]    cmd_o;
    logic [7:0]    len_o;
    logic [7:0]    rd_data;
    logic          err_chk, err_len, err_ovf, err_tmo;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t held;
    logic prev_valid = 1'b0;

    uart_frame_ctrl #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_L       (rst_n),
        .i_RX_DV       (rx_dv),
        .i_RX_Byte     (rx_byte),
        .o_Frame_Valid (frame_valid),
        .o_Cmd         (cmd_o),
        .o_Len         (len_o),
        .i_Rd_Addr     (rd_addr),
        .o_Rd_Data     (rd_data),
        .i_Frame_Ack   (ack),
        .o_Err_Chk     (err_chk),
        .o_Err_Len     (err_len),
        .o_Err_Ovf     (err_ovf),
        .o_Err_Tmo     (err_tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, expected finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input logic [2:0] k, input int at, input logic [7:0] c,
                                      input logic [7:0] l, input logic [MAX_LEN*8-1:0] p);
        exp_t e;
        e.kind = k;
        e.cyc  = 32'(at);
        e.cmd  = c;
        e.len  = l;
        e.pay  = p;
        sb.push_back(e);
    endfunction

    // Monitor: any DUT event pops the oldest expectation and is compared.
    task automatic observe(input logic [2:0] kind);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        chk("event_cycle", 32'(cyc), e.cyc);
        if (e.kind == K_VALID || e.kind == K_OVF) begin
            chk("frame_valid", 32'(frame_valid), 32'd1);
            chk("cmd", 32'(cmd_o), 32'(e.cmd));
            chk("len", 32'(len_o), 32'(e.len));
            for (int i = 0; i < int'(e.len); i++) begin
                rd_addr = AW'(i);
                #0.1;
                chk("rd_data", 32'(rd_data), 32'(e.pay[i*8 +: 8]));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_valid && !prev_valid) observe(K_VALID);
                if (err_chk) observe(K_CHK);
                if (err_len) observe(K_LEN);
                if (err_ovf) observe(K_OVF);
                if (err_tmo) observe(K_TMO);
            end
            prev_valid = frame_valid;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom);
        idle_cycles($urandom_range(1, 3));
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == SYNC_BYTE) b = 8'h00;
            send_byte(b);
        end
    endtask

    // Frame outcome follows directly from the format rules: oversize length,
    // checksum (XOR of cmd, len, payload) match, or mismatch.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] l,
                              input logic [MAX_LEN*8-1:0] p, input logic [7:0] bad_xor,
                              input bit skip_sync, output bit good);
        logic [7:0] x;
        good = 1'b0;
        if (!skip_sync) send_byte(SYNC_BYTE);
        send_byte(c);
        if (int'(l) > MAX_LEN) begin
            expect_ev(K_LEN, cyc + 1, c, l, p);
            send_byte(l);
            send_garbage($urandom_range(0, 2));
            return;
        end
        send_byte(l);
        x = c ^ l;
        for (int i = 0; i < int'(l); i++) begin
            x ^= p[i*8 +: 8];
            send_byte(p[i*8 +: 8]);
        end
        if (bad_xor == 8'h00) begin
            expect_ev(K_VALID, cyc + 1, c, l, p);
            held.cmd = c;
            held.len = l;
            held.pay = p;
            good = 1'b1;
        end else begin
            expect_ev(K_CHK, cyc + 1, c, l, p);
        end
        send_byte(x ^ bad_xor);
    endtask

    task automatic hold_phase(input bit allow_chain, output bit chained);
        chained = 1'b0;
        chk("valid_held", 32'(frame_valid), 32'd1);
        repeat ($urandom_range(0, 2)) begin
            expect_ev(K_OVF, cyc + 1, held.cmd, held.len, held.pay);
            send_byte(8'($urandom));
        end
        if (allow_chain && $urandom_range(0, 1) == 1) begin
            ack     = 1'b1;
            rx_dv   = 1'b1;
            rx_byte = SYNC_BYTE;
            @(posedge clk);
            #1;
            ack   = 1'b0;
            rx_dv = 1'b0;
            chk("valid_release_chain", 32'(frame_valid), 32'd0);
            chained = 1'b1;
            idle_cycles($urandom_range(1, 3));
        end else begin
            idle_cycles($urandom_range(0, 3));
            ack = 1'b1;
            @(posedge clk);
            #1;
            ack = 1'b0;
            chk("valid_after_ack", 32'(frame_valid), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, "_cmd"}, 32'(cmd_o), 32'd0);
        chk({tag, "_len"}, 32'(len_o), 32'd0);
        chk({tag, "_errs"}, 32'({err_chk, err_len, err_ovf, err_tmo}), 32'd0);
    endtask

    initial begin
        logic [MAX_LEN*8-1:0] p;
        logic [7:0]           c, l, bx;
        bit                   good, chained;
        int                   r;

        idle_cycles(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // Directed frames from the format description.
        send_frame(8'h10, 8'h03, {{(MAX_LEN-3){8'h00}}, 8'h33, 8'h22, 8'h11}, 8'h00, 1'b0, good);
        hold_phase(1'b0, chained);
        send_frame(8'h7F, 8'h00, '0, 8'h00, 1'b0, good);
        hold_phase(1'b0, chained);
        send_frame(8'h10, 8'h01, {{(MAX_LEN-1){8'h00}}, 8'hAA}, 8'hBB, 1'b0, good);
        send_frame(8'h01, 8'h11, '0, 8'h00, 1'b0, good);
        send_frame(8'h10, 8'h03, {{(MAX_LEN-3){8'h00}}, 8'h33, 8'h22, 8'h11}, 8'h00, 1'b0, good);
        hold_phase(1'b0, chained);

`ifdef UART_FRAME_TIMEOUT_EN
        send_byte(SYNC_BYTE);
        expect_ev(K_TMO, cyc + 1 + TIMEOUT_CLKS, 8'h00, 8'h00, '0);
        send_byte(8'h10);
        idle_cycles(TIMEOUT_CLKS + 10);
        send_frame(8'h22, 8'h01, {{(MAX_LEN-1){8'h00}}, 8'h5A}, 8'h00, 1'b0, good);
        hold_phase(1'b0, chained);
`endif

        chained = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (!chained) begin
                send_garbage($urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) begin
                    ack = 1'b1;
                    @(posedge clk);
                    #1;
                    ack = 1'b0;
                    idle_cycles(1);
                end
            end
            for (int i = 0; i < MAX_LEN; i++) p[i*8 +: 8] = 8'($urandom);
            c  = 8'($urandom);
            r  = $urandom_range(0, 9);
            bx = 8'h00;
            if (r >= 8) l = 8'($urandom_range(MAX_LEN + 1, 255));
            else        l = 8'($urandom_range(0, MAX_LEN));
            if (r == 6 || r == 7) bx = 8'($urandom_range(1, 255));
            send_frame(c, l, p, bx, chained, good);
            chained = 1'b0;
            if (good) hold_phase(n < 59, chained);
        end

        // Reset in the middle of a payload discards the partial frame silently.
        send_byte(SYNC_BYTE);
        send_byte(8'h3C);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);
        send_frame(8'h44, 8'h02, {{(MAX_LEN-2){8'h00}}, 8'hA5, 8'h0F}, 8'h00, 1'b0, good);
        hold_phase(1'b0, chained);

        idle_cycles(5);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Frame controller behind the UART receiver: consumes the receiver's one-cycle byte strobes and sequences them through a fixed packet format (sync, command, length, payload, checksum). Validated frames are held in an internal payload buffer and presented to the host logic through a valid/ack handshake. Malformed, overlong or stalled frames are discarded with an error pulse. The block is the single consumer of the receiver's output.

## Interface
- `MAX_LEN`, default 16: maximum payload bytes, 1..255.
- `TIMEOUT_CLKS`, default 8680: inter-byte timeout in clocks; default is 4 character times at 217 clocks per bit.
- `i_Clock`  in  1: sole clock.
- `i_Rst_L`  in  1: reset, asynchronous, active-low.
- `i_RX_DV`  in  1: byte strobe from the receiver, one cycle wide.
- `i_RX_Byte`  in  8: received byte, valid when `i_RX_DV`=1.
- `o_Frame_Valid`  out  1: a good frame is held.
- `o_Cmd`  out  8: command byte of the held frame.
- `o_Len`  out  8: payload length of the held frame.
- `i_Rd_Addr`  in  $clog2(MAX_LEN): payload read index.
- `o_Rd_Data`  out  8: payload byte at `i_Rd_Addr`; combinational read.
- `i_Frame_Ack`  in  1: host releases the held frame.
- `o_Err_Chk`  out  1: one-cycle pulse on checksum mismatch.
- `o_Err_Len`  out  1: one-cycle pulse on LEN > MAX_LEN.
- `o_Err_Ovf`  out  1: one-cycle pulse when a byte arrives while a frame is held.
- `o_Err_Tmo`  out  1: one-cycle pulse on inter-byte timeout (see Configuration).

## Operation
- Frame format:
  - 0xA5 (SYNC), CMD, LEN, LEN payload bytes, CHK.
  - CHK = XOR of CMD, LEN and every payload byte.
- States:
  - IDLE: byte==SYNC → CMD. Any other byte is discarded silently.
  - CMD: store the byte as CMD; seed checksum accumulator = byte → LEN.
  - LEN:
    - byte > MAX_LEN → pulse `o_Err_Len` → IDLE.
    - byte==0 → CHK.
    - otherwise → PAYLOAD.
    - The length byte is XORed into the accumulator in every case.
  - PAYLOAD: write byte to buffer[idx], XOR into accumulator, idx++. After byte LEN-1 → CHK.
  - CHK:
    - byte == accumulator → HOLD.
    - otherwise pulse `o_Err_Chk` → IDLE.
  - HOLD: `o_Frame_Valid`=1.
    - `i_Frame_Ack` → IDLE.
    - `i_RX_DV` without ack → pulse `o_Err_Ovf`; byte dropped.
- A SYNC value inside CMD, LEN, PAYLOAD or CHK is ordinary data; there is no resync.
- Index counter width: $clog2(MAX_LEN)+1. It is cleared on entry to PAYLOAD.
- `o_Cmd`, `o_Len` and the buffer change only while outside HOLD. Their contents are meaningful only while `o_Frame_Valid`=1.
- `i_Rd_Addr` ≥ `o_Len`: `o_Rd_Data` is the stale buffer contents; this is not an error.

## Timing
- Reset values: state IDLE; all outputs 0; accumulator, idx and timeout counter 0. Buffer contents are not reset.
- Reset asserted mid-frame: the partial frame is lost; no error pulse is generated.
- Each state transition occurs on the clock edge where `i_RX_DV`=1.
- `o_Frame_Valid` rises on the cycle after the CHK byte's strobe and stays high until the ack edge.
- `o_Frame_Valid` falls on the cycle after `i_Frame_Ack` is sampled high in HOLD. Ack outside HOLD is ignored.
- Ack and `i_RX_DV` in the same HOLD cycle: the frame is released, and the byte is processed as in IDLE (SYNC → CMD). No `o_Err_Ovf` is generated.
- Error pulses are registered, one cycle wide, and appear on the cycle after the offending strobe.
- Minimum spacing of `i_RX_DV` is 2 cycles; back-to-back strobes need not be supported.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined:
  - A counter clears on every `i_RX_DV` and increments each cycle in CMD, LEN, PAYLOAD and CHK.
  - When it reaches TIMEOUT_CLKS-1 with no strobe: pulse `o_Err_Tmo` → IDLE.
  - The counter is held at 0 in IDLE and HOLD.
- Undefined: no counter is built; `o_Err_Tmo` is tied 0; a stalled frame waits indefinitely.

## Structure
- Package `uart_frame_pkg`: state encoding (IDLE, CMD, LEN, PAYLOAD, CHK, HOLD as 3-bit constants) and `SYNC_BYTE`=8'hA5.
- Sub-module `uart_frame_buf`: MAX_LEN×8 register file with synchronous write and asynchronous read.
- The FSM, accumulator, index counter and timeout counter live in `uart_frame_ctrl`.

## Test plan
- Good frame:
  - Stimulus: A5 10 03 11 22 33 CHK=0x13.
  - Response: `o_Frame_Valid`=1 one cycle after CHK; `o_Cmd`=0x10, `o_Len`=3; reads at addresses 0/1/2 return 11/22/33.
  - Ack → valid low next cycle.
- Zero length: A5 7F 00 7F → valid with `o_Len`=0.
- Bad checksum: A5 10 01 AA 00 → `o_Err_Chk` pulse, no valid, state IDLE. A following good frame is accepted.
- Length error (MAX_LEN=16): A5 01 11 → `o_Err_Len` pulse. Subsequent garbage bytes (not A5) are ignored.
- Overflow and simultaneous events:
  - Byte sent while HOLD, no ack → `o_Err_Ovf`, held frame unchanged.
  - Ack coincident with an A5 strobe → release, then the new frame parses correctly.
- Timeout (macro on, TIMEOUT_CLKS=100): A5 10, then 100 idle cycles → `o_Err_Tmo` pulse, IDLE.
- Reset: `i_Rst_L` low mid-payload → all outputs 0 and IDLE on the same edge.
